// File: rtl/nios_debug_cmd_decoder.sv
// System-clock side of the CPU debug slave: TCK strobe synchronisation, buffered command capture and one-hot action decode.
// Optional pop/drop counters are enabled by defining NIOS_DEBUG_CMD_COUNT_EN.
module nios_debug_cmd_decoder #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = 35,
  localparam int NUM_CMD    = 2**IR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vs_uir,
  input  logic               vs_udr,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [DR_W-1:0]    sr,
  input  logic               cmd_ready,
  input  logic               ovf_clr,
  output logic               cmd_valid,
  output logic [IR_W-1:0]    cmd_ir,
  output logic [DR_W-1:0]    jdo,
  output logic [IR_W-1:0]    ir_q,
  output logic [NUM_CMD-1:0] take_action,
  output logic [NUM_CMD-1:0] take_no_action,
  output logic               overflow
`ifdef NIOS_DEBUG_CMD_COUNT_EN
  ,
  output logic [15:0]        cmd_count,
  output logic [15:0]        drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = IR_W + DR_W;

  logic [SYNC_STAGES-1:0] uir_sync_r;
  logic [SYNC_STAGES-1:0] udr_sync_r;
  logic                   uir_dly_r;
  logic                   udr_dly_r;
  logic                   uir_rise_s;
  logic                   udr_rise_s;

  logic [EW-1:0]          mem_r [DEPTH];
  logic [AW:0]            wr_ptr_r;
  logic [AW:0]            rd_ptr_r;
  logic [AW:0]            wr_ptr_nxt_s;
  logic [AW:0]            rd_ptr_nxt_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_ok_s;
  logic                   drop_s;
  logic                   valid_nxt_s;
  logic [EW-1:0]          head_nxt_s;
  logic [NUM_CMD-1:0]     onehot_s;

  // Synchronise both TCK-domain strobes and keep a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_r <= {SYNC_STAGES{1'b0}};
      udr_sync_r <= {SYNC_STAGES{1'b0}};
      uir_dly_r  <= 1'b0;
      udr_dly_r  <= 1'b0;
    end else begin
      uir_sync_r <= {uir_sync_r[SYNC_STAGES-2:0], vs_uir};
      udr_sync_r <= {udr_sync_r[SYNC_STAGES-2:0], vs_udr};
      uir_dly_r  <= uir_sync_r[SYNC_STAGES-1];
      udr_dly_r  <= udr_sync_r[SYNC_STAGES-1];
    end
  end

  // FIFO control and the next head entry, computed ahead so the head outputs can be registered.
  always_comb begin
    uir_rise_s   = uir_sync_r[SYNC_STAGES-1] & ~uir_dly_r;
    udr_rise_s   = udr_sync_r[SYNC_STAGES-1] & ~udr_dly_r;
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s        = cmd_valid & cmd_ready;
    push_ok_s    = udr_rise_s & (~full_s | pop_s);
    drop_s       = udr_rise_s & full_s & ~pop_s;
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + (AW+1)'(1)) : rd_ptr_r;
    wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + (AW+1)'(1)) : wr_ptr_r;
    valid_nxt_s  = (rd_ptr_nxt_s != wr_ptr_nxt_s);
    // When the queue drains to the write pointer, the only possible head is the entry being pushed now.
    if (rd_ptr_nxt_s == wr_ptr_r) begin
      if (push_ok_s) begin
        head_nxt_s = {ir_q, sr};
      end else begin
        head_nxt_s = {cmd_ir, jdo};
      end
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
    onehot_s = {{(NUM_CMD-1){1'b0}}, 1'b1} << cmd_ir;
  end

  // Command storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= {ir_q, sr};
      end
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Registered head view, latched IR, decode pulses and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid      <= 1'b0;
      cmd_ir         <= {IR_W{1'b0}};
      jdo            <= {DR_W{1'b0}};
      ir_q           <= {IR_W{1'b0}};
      take_action    <= {NUM_CMD{1'b0}};
      take_no_action <= {NUM_CMD{1'b0}};
      overflow       <= 1'b0;
    end else begin
      cmd_valid         <= valid_nxt_s;
      {cmd_ir, jdo}     <= head_nxt_s;
      if (uir_rise_s) begin
        ir_q <= ir_in;
      end
      take_action    <= (pop_s &  jdo[ACTION_BIT]) ? onehot_s : {NUM_CMD{1'b0}};
      take_no_action <= (pop_s & ~jdo[ACTION_BIT]) ? onehot_s : {NUM_CMD{1'b0}};
      // A fresh drop outranks a simultaneous clear.
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef NIOS_DEBUG_CMD_COUNT_EN
  // Saturating pop and drop counters; a drop coinciding with a clear restarts the drop count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_count  <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (pop_s && (cmd_count != 16'hFFFF)) begin
        cmd_count <= cmd_count + 16'd1;
      end
      if (ovf_clr) begin
        drop_count <= drop_s ? 16'd1 : 16'd0;
      end else if (drop_s && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule
